mem_stage_lsu: RTL

// - MEM-stage consumer of the EX/MEM register: performs loads/stores on a data-memory bus, aligns and extends data, and registers MEM/WB results.
// - Sits between the EX/MEM register outputs and the MEM/WB boundary.
// - Holds the pipeline via stall_out while a memory transaction is outstanding.

---
 rtl/mem_stage_lsu_if.sv | 15 +
 rtl/mem_stage_lsu.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_lsu_if.sv
// Data-memory bus between the MEM-stage LSU (master) and data memory (slave).
// Request/grant handshake, then a single-beat read response on rvalid.
interface mem_stage_lsu_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, we, addr, wdata, be, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, be, output gnt, rvalid, rdata);
endinterface

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: ALU ops retire next edge, stores on the gnt edge, loads on the rvalid edge.
// Combinational stall_out holds upstream while a bus op is open; `define MISALIGN_TRAP_EN traps misaligned H/W.
module mem_stage_lsu #(
  parameter int         RESP_TIMEOUT = 255,
  parameter logic [1:0] MEM_SEL      = 2'b01
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     result_in,
  input  logic [31:0]     data2_in,
  input  logic [31:0]     sum_out_in,
  input  logic [31:0]     imm_in,
  input  logic [4:0]      rd_in,
  input  logic            we_in,
  input  logic [1:0]      controlRF_in,
  input  logic [2:0]      Type_dm_in,
  input  logic            store_in,
  mem_stage_lsu_if.master dmem,
  output logic            stall_out,
  output logic [31:0]     wb_data_out,
  output logic [4:0]      rd_out,
  output logic            we_out,
  output logic            bus_err_out
`ifdef MISALIGN_TRAP_EN
  ,
  output logic            misalign_out
`endif
);
  localparam int CW = (RESP_TIMEOUT < 2) ? 1 : $clog2(RESP_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t        state;
  logic [CW-1:0] cnt;

  logic        mem_op, is_b, is_h, sext, misalign;
  logic        timeout_hit, store_done, load_done, abort;
  logic [1:0]  lane;
  logic [3:0]  be_nxt;
  logic [31:0] wdata_nxt, rshift, load_data, wb_sel;

  assign mem_op = store_in | (controlRF_in == MEM_SEL);
  assign is_b   = (Type_dm_in[1:0] == 2'b00);
  assign is_h   = (Type_dm_in[1:0] == 2'b01);
  assign sext   = ~Type_dm_in[2];

`ifdef MISALIGN_TRAP_EN
  assign misalign = mem_op & (is_h ? result_in[0] : (~is_b & (result_in[1:0] != 2'b00)));
`else
  assign misalign = 1'b0;
`endif

  // Sub-word offset; H uses only a[1], W (and undefined codes) always lane 0.
  assign lane = is_b ? result_in[1:0] : (is_h ? {result_in[1], 1'b0} : 2'b00);

  always_comb begin
    be_nxt    = 4'b1111;
    wdata_nxt = data2_in;
    if (is_b) begin
      be_nxt    = 4'b0001 << lane;
      wdata_nxt = {4{data2_in[7:0]}};
    end else if (is_h) begin
      be_nxt    = 4'b0011 << lane;
      wdata_nxt = {2{data2_in[15:0]}};
    end
  end

  assign rshift = dmem.rdata >> {lane, 3'b000};

  always_comb begin
    load_data = rshift;
    if (is_b)
      load_data = {{24{sext & rshift[7]}}, rshift[7:0]};
    else if (is_h)
      load_data = {{16{sext & rshift[15]}}, rshift[15:0]};
  end

  always_comb begin
    wb_sel = result_in;
    if (controlRF_in == MEM_SEL)
      wb_sel = load_data;
    else if (controlRF_in == 2'b10)
      wb_sel = sum_out_in;
    else if (controlRF_in == 2'b11)
      wb_sel = imm_in;
  end

  assign timeout_hit = (RESP_TIMEOUT != 0) && (state != IDLE) && (cnt == CW'(RESP_TIMEOUT - 1));
  assign store_done  = (state == REQ) & dmem.gnt & store_in;
  assign load_done   = (state == RESP) & dmem.rvalid;
  // A grant or response arriving on the last allowed cycle still wins over the abort.
  assign abort       = timeout_hit & ~((state == REQ) & dmem.gnt) & ~load_done;

  // An aborted op also releases upstream, otherwise the held op would be reissued.
  assign stall_out = (state == IDLE) ? (mem_op & ~misalign)
                                     : ~(store_done | load_done | abort);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      dmem.req     <= 1'b0;
      dmem.we      <= 1'b0;
      dmem.addr    <= '0;
      dmem.wdata   <= '0;
      dmem.be      <= '0;
      wb_data_out  <= '0;
      rd_out       <= '0;
      we_out       <= 1'b0;
      bus_err_out  <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      misalign_out <= 1'b0;
`endif
    end else begin
      bus_err_out  <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      misalign_out <= 1'b0;
`endif
      cnt          <= cnt + 1'b1;
      if (abort) begin
        state       <= IDLE;
        cnt         <= '0;
        dmem.req    <= 1'b0;
        bus_err_out <= 1'b1;
        wb_data_out <= '0;
        rd_out      <= rd_in;
        we_out      <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            cnt <= '0;
            if (misalign) begin
              wb_data_out  <= '0;
              rd_out       <= rd_in;
              we_out       <= 1'b0;
`ifdef MISALIGN_TRAP_EN
              misalign_out <= 1'b1;
`endif
            end else if (mem_op) begin
              state      <= REQ;
              dmem.req   <= 1'b1;
              dmem.we    <= store_in;
              dmem.addr  <= {result_in[31:2], 2'b00};
              dmem.wdata <= wdata_nxt;
              dmem.be    <= be_nxt;
            end else begin
              wb_data_out <= wb_sel;
              rd_out      <= rd_in;
              we_out      <= we_in;
            end
          end
          REQ: begin
            if (dmem.gnt) begin
              dmem.req <= 1'b0;
              cnt      <= '0;
              if (store_in) begin
                state       <= IDLE;
                wb_data_out <= wb_sel;
                rd_out      <= rd_in;
                we_out      <= 1'b0;
              end else begin
                state <= RESP;
              end
            end
          end
          RESP: begin
            if (dmem.rvalid) begin
              state       <= IDLE;
              cnt         <= '0;
              wb_data_out <= wb_sel;
              rd_out      <= rd_in;
              we_out      <= we_in;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
